// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcodes, state encodings, strobe bundle and opcode classifier for the control sequencer
package control_pkg;

   // Opcode field sits in the top OPC_W_DEF bits of an IR_W_DEF-bit instruction
   localparam int IR_W_DEF  = 32;
   localparam int OPC_W_DEF = 5;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [4:0] {
      RST     = 5'd0,
      BOOT    = 5'd1,
      T0      = 5'd2,
      T1      = 5'd3,
      T2      = 5'd4,
      T3      = 5'd5,
      T4      = 5'd6,
      T5      = 5'd7,
      T6      = 5'd8,
      T7      = 5'd9,
      STOPPED = 5'd10,
      HALT    = 5'd11
   } state_e;

   typedef enum logic [2:0] {C_LD, C_LDI, C_ST, C_BR, C_JR, C_NOP, C_HALT} op_e;

   typedef struct packed {
      logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout;
      logic IRin, Yin, Yout, Cout, BAout, Gra, Grb, Grc, Rin, Rout;
      logic HIin, LOin, HIout, LOout, CONin, OUTPORTin, INPORTout, write;
   } strobes_t;

   // Unlisted opcodes fall into the NOP class
   function automatic op_e op_class(input logic [4:0] opc);
      case (opc)
         OP_LD:   return C_LD;
         OP_LDI:  return C_LDI;
         OP_ST:   return C_ST;
         OP_BR:   return C_BR;
         OP_JR:   return C_JR;
         OP_HALT: return C_HALT;
         default: return C_NOP;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control-to-datapath strobe bundle; Mem_ready exists only with CONTROL_SEQ_MEM_WAIT_EN
interface control_sequencer_if
   import control_pkg::*;
#(
   parameter int IR_W = IR_W_DEF
);
   logic [IR_W-1:0] IRregister;
   logic CON, Stop, Run;
`ifdef CONTROL_SEQ_MEM_WAIT_EN
   logic Mem_ready;
`endif
   logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout;
   logic IRin, Yin, Yout, Cout, BAout, Gra, Grb, Grc, Rin, Rout;
   logic HIin, LOin, HIout, LOout, CONin, OUTPORTin, INPORTout, write;

   modport master (
      input  IRregister, CON, Stop,
`ifdef CONTROL_SEQ_MEM_WAIT_EN
      input  Mem_ready,
`endif
      output Run,
      output PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout,
      output IRin, Yin, Yout, Cout, BAout, Gra, Grb, Grc, Rin, Rout,
      output HIin, LOin, HIout, LOout, CONin, OUTPORTin, INPORTout, write
   );

   modport slave (
      output IRregister, CON, Stop,
`ifdef CONTROL_SEQ_MEM_WAIT_EN
      output Mem_ready,
`endif
      input  Run,
      input  PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout,
      input  IRin, Yin, Yout, Cout, BAout, Gra, Grb, Grc, Rin, Rout,
      input  HIin, LOin, HIout, LOout, CONin, OUTPORTin, INPORTout, write
   );
endinterface

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational strobe decode from sequencer state, opcode class and CON
module control_decode
   import control_pkg::*;
(
   input  state_e   state,
   input  op_e      op,
   input  logic     CON,
   output strobes_t strb
);

   always_comb begin
      strb = '0;
      case (state)
         BOOT: begin strb.INPORTout = 1'b1; strb.PCin = 1'b1; end
         T0:   begin strb.PCout = 1'b1; strb.MARin = 1'b1; strb.IncPC = 1'b1; strb.Zin = 1'b1; end
         T1:   begin strb.ZLOout = 1'b1; strb.PCin = 1'b1; strb.Read = 1'b1; strb.MDRin = 1'b1; end
         T2:   begin strb.MDRout = 1'b1; strb.IRin = 1'b1; end
         T3: case (op)
            C_LD, C_LDI, C_ST: begin strb.Grb = 1'b1; strb.BAout = 1'b1; strb.Yin = 1'b1; end
            C_BR: begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.CONin = 1'b1; end
            C_JR: begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.PCin = 1'b1; end
            default: ;
         endcase
         T4: case (op)
            C_LD, C_LDI, C_ST: begin strb.Cout = 1'b1; strb.Zin = 1'b1; end
            C_BR: begin strb.PCout = 1'b1; strb.Yin = 1'b1; end
            default: ;
         endcase
         T5: case (op)
            C_LD, C_ST: begin strb.ZLOout = 1'b1; strb.MARin = 1'b1; end
            C_LDI: begin strb.ZLOout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
            C_BR:  begin strb.Cout = 1'b1; strb.Zin = 1'b1; end
            default: ;
         endcase
         T6: case (op)
            C_LD: begin strb.Read = 1'b1; strb.MDRin = 1'b1; end
            // Store loads MDR from the bus, so Read stays low here
            C_ST: begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.MDRin = 1'b1; end
            C_BR: begin strb.ZLOout = 1'b1; strb.PCin = CON; end
            default: ;
         endcase
         T7: case (op)
            C_LD: begin strb.MDRout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
            C_ST: strb.write = 1'b1;
            default: ;
         endcase
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute sequencer; CONTROL_SEQ_MEM_WAIT_EN adds Mem_ready wait states
module control_sequencer
   import control_pkg::*;
#(
   parameter int IR_W  = IR_W_DEF,
   parameter int OPC_W = OPC_W_DEF
)(
   input  logic                Clock,
   input  logic                Reset_n,
   control_sequencer_if.master bus
);

   state_e         state;
   state_e         resume;
   op_e            op;
   strobes_t       strb;
   logic [OPC_W-1:0] opc;
   logic           unused_ir;

   assign opc       = bus.IRregister[IR_W-1 -: OPC_W];
   assign unused_ir = ^bus.IRregister[IR_W-OPC_W-1:0];
   assign op        = op_class(5'(opc));
   // Stop is only honoured at an instruction boundary
   assign resume    = bus.Stop ? STOPPED : T0;

   control_decode u_decode (
      .state (state),
      .op    (op),
      .CON   (bus.CON),
      .strb  (strb)
   );

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= RST;
`ifdef CONTROL_SEQ_MEM_WAIT_EN
      end else if ((strb.Read || strb.write) && !bus.Mem_ready) begin
         state <= state;
`endif
      end else begin
         case (state)
            RST:     state <= BOOT;
            BOOT:    state <= resume;
            T0:      state <= T1;
            T1:      state <= T2;
            T2:      state <= T3;
            T3: case (op)
               C_LD, C_LDI, C_ST, C_BR: state <= T4;
               C_HALT:                  state <= HALT;
               default:                 state <= resume;
            endcase
            T4:      state <= T5;
            T5:      state <= (op == C_LDI) ? resume : T6;
            T6:      state <= (op == C_BR) ? resume : T7;
            T7:      state <= resume;
            STOPPED: state <= bus.Stop ? STOPPED : T0;
            HALT:    state <= HALT;
            default: state <= BOOT;
         endcase
      end
   end

   assign bus.Run = state inside {BOOT, T0, T1, T2, T3, T4, T5, T6, T7};

   assign bus.PCout = strb.PCout;   assign bus.MARin = strb.MARin;   assign bus.IncPC = strb.IncPC;
   assign bus.Zin = strb.Zin;       assign bus.ZLOout = strb.ZLOout; assign bus.ZHIout = strb.ZHIout;
   assign bus.PCin = strb.PCin;     assign bus.Read = strb.Read;     assign bus.MDRin = strb.MDRin;
   assign bus.MDRout = strb.MDRout; assign bus.IRin = strb.IRin;     assign bus.Yin = strb.Yin;
   assign bus.Yout = strb.Yout;     assign bus.Cout = strb.Cout;     assign bus.BAout = strb.BAout;
   assign bus.Gra = strb.Gra;       assign bus.Grb = strb.Grb;       assign bus.Grc = strb.Grc;
   assign bus.Rin = strb.Rin;       assign bus.Rout = strb.Rout;     assign bus.HIin = strb.HIin;
   assign bus.LOin = strb.LOin;     assign bus.HIout = strb.HIout;   assign bus.LOout = strb.LOout;
   assign bus.CONin = strb.CONin;   assign bus.OUTPORTin = strb.OUTPORTin;
   assign bus.INPORTout = strb.INPORTout;
   assign bus.write = strb.write;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - cycle-by-cycle check of control_sequencer against an instruction-level strobe model
module tb_control_sequencer;
   import control_pkg::*;

   localparam logic [31:0] I_LD   = 32'h00800075;
   localparam logic [31:0] I_LDI  = {5'b00001, 27'h0123456};
   localparam logic [31:0] I_ST   = {5'b00010, 27'h0000abc};
   localparam logic [31:0] I_BR   = {5'b10010, 27'h0000010};
   localparam logic [31:0] I_JR   = {5'b10100, 27'h0000001};
   localparam logic [31:0] I_NOP  = {5'b11010, 27'h0};
   localparam logic [31:0] I_UNK  = {5'b11111, 27'h7ffffff};
   localparam logic [31:0] I_HALT = {5'b11011, 27'h0};

   typedef struct {
      logic        rst_n;
      logic [31:0] ir;
      logic        con;
      logic        stop;
      logic        mr;
      strobes_t    exp;
      logic        run;
      string       tag;
   } cyc_t;

   logic     Clock;
   logic     Reset_n;
   strobes_t act;
   cyc_t     plan[$];
   int       checks;
   int       errors;
   int       n;

   control_sequencer_if bus ();

   control_sequencer dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always_comb act = '{PCout:bus.PCout, MARin:bus.MARin, IncPC:bus.IncPC, Zin:bus.Zin,
      ZLOout:bus.ZLOout, ZHIout:bus.ZHIout, PCin:bus.PCin, Read:bus.Read, MDRin:bus.MDRin,
      MDRout:bus.MDRout, IRin:bus.IRin, Yin:bus.Yin, Yout:bus.Yout, Cout:bus.Cout,
      BAout:bus.BAout, Gra:bus.Gra, Grb:bus.Grb, Grc:bus.Grc, Rin:bus.Rin, Rout:bus.Rout,
      HIin:bus.HIin, LOin:bus.LOin, HIout:bus.HIout, LOout:bus.LOout, CONin:bus.CONin,
      OUTPORTin:bus.OUTPORTin, INPORTout:bus.INPORTout, write:bus.write};

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, got, want);
      end
   endtask

   task automatic add(input logic rst_n, input logic [31:0] ir, input logic con, input logic stop,
                      input logic mr, input strobes_t e, input logic run, input string tag);
      cyc_t c;
      c.rst_n = rst_n; c.ir = ir; c.con = con; c.stop = stop; c.mr = mr;
      c.exp = e; c.run = run; c.tag = tag;
      plan.push_back(c);
   endtask

   task automatic boot_seq();
      strobes_t e;
      e = '0; e.INPORTout = 1'b1; e.PCin = 1'b1;
      add(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, e, 1'b1, "boot");
   endtask

   // Expected strobe list per instruction, step by step from T0
   task automatic instr(input logic [31:0] ir, input logic con, input int stop_from, input int t1_wait,
                        input int max_steps, input string tag, output int len);
      strobes_t   st[$];
      strobes_t   e;
      logic [4:0] opc;
      opc = ir[31:27];
      e = '0; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; st.push_back(e);
      e = '0; e.ZLOout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1; st.push_back(e);
      e = '0; e.MDRout = 1; e.IRin = 1; st.push_back(e);
      if (opc == 5'b00000 || opc == 5'b00001 || opc == 5'b00010) begin
         e = '0; e.Grb = 1; e.BAout = 1; e.Yin = 1; st.push_back(e);
         e = '0; e.Cout = 1; e.Zin = 1; st.push_back(e);
         if (opc == 5'b00001) begin
            e = '0; e.ZLOout = 1; e.Gra = 1; e.Rin = 1; st.push_back(e);
         end else begin
            e = '0; e.ZLOout = 1; e.MARin = 1; st.push_back(e);
            if (opc == 5'b00000) begin
               e = '0; e.Read = 1; e.MDRin = 1; st.push_back(e);
               e = '0; e.MDRout = 1; e.Gra = 1; e.Rin = 1; st.push_back(e);
            end else begin
               e = '0; e.Gra = 1; e.Rout = 1; e.MDRin = 1; st.push_back(e);
               e = '0; e.write = 1; st.push_back(e);
            end
         end
      end else if (opc == 5'b10010) begin
         e = '0; e.Gra = 1; e.Rout = 1; e.CONin = 1; st.push_back(e);
         e = '0; e.PCout = 1; e.Yin = 1; st.push_back(e);
         e = '0; e.Cout = 1; e.Zin = 1; st.push_back(e);
         e = '0; e.ZLOout = 1; e.PCin = con; st.push_back(e);
      end else if (opc == 5'b10100) begin
         e = '0; e.Gra = 1; e.Rout = 1; e.PCin = 1; st.push_back(e);
      end else begin
         st.push_back('0);
      end
      for (int i = 0; i < st.size() && (max_steps < 0 || i < max_steps); i++) begin
         if (i == 1) repeat (t1_wait) add(1'b1, ir, con, 1'b0, 1'b0, st[i], 1'b1, {tag, "_T1w"});
         add(1'b1, ir, con, (stop_from >= 0 && i >= stop_from), 1'b1, st[i], 1'b1,
             $sformatf("%s_T%0d", tag, i));
      end
      len = st.size() + t1_wait;
   endtask

   initial begin
      checks = 0; errors = 0;
      Reset_n = 1'b0;
      bus.IRregister = '0; bus.CON = 1'b0; bus.Stop = 1'b0;
`ifdef CONTROL_SEQ_MEM_WAIT_EN
      bus.Mem_ready = 1'b1;
`endif

      repeat (3) add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0, 1'b0, "rst");
      add(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, '0, 1'b0, "rst_rel");
      boot_seq();
      instr(I_LD,  1'b0, -1, 0, -1, "ld",   n); chk("len_LD", 64'(n), 64'd8);
      instr(I_LDI, 1'b0, -1, 0, -1, "ldi",  n); chk("len_LDI", 64'(n), 64'd6);
      instr(I_ST,  1'b0, -1, 0, -1, "st",   n); chk("len_ST", 64'(n), 64'd8);
      instr(I_BR,  1'b0, -1, 0, -1, "br0",  n); chk("len_BR", 64'(n), 64'd7);
      instr(I_BR,  1'b1, -1, 0, -1, "br1",  n);
      instr(I_JR,  1'b0, -1, 0, -1, "jr",   n); chk("len_JR", 64'(n), 64'd4);
      instr(I_NOP, 1'b0, -1, 0, -1, "nop",  n); chk("len_NOP", 64'(n), 64'd4);
      instr(I_UNK, 1'b1, -1, 0, -1, "unk",  n);
      instr(I_LD,  1'b0,  4, 0, -1, "ldstp", n);
      add(1'b1, I_LD, 1'b0, 1'b1, 1'b1, '0, 1'b0, "stopped");
      add(1'b1, I_LD, 1'b0, 1'b1, 1'b1, '0, 1'b0, "stopped");
      add(1'b1, I_LD, 1'b0, 1'b0, 1'b1, '0, 1'b0, "stopped");
      instr(I_NOP, 1'b0, -1, 0, -1, "nop2", n);
`ifdef CONTROL_SEQ_MEM_WAIT_EN
      instr(I_LDI, 1'b0, -1, 3, -1, "ldiw", n); chk("len_LDI_wait", 64'(n), 64'd9);
`endif
      instr(I_LD,  1'b0, -1, 0,  5, "ldrst", n);
      add(1'b0, I_LD, 1'b0, 1'b0, 1'b1, '0, 1'b0, "midrst");
      add(1'b1, I_LD, 1'b0, 1'b0, 1'b1, '0, 1'b0, "rst_rel");
      boot_seq();
      instr(I_JR,  1'b0, -1, 0, -1, "jr2",  n);
      instr(I_HALT, 1'b0, -1, 0, -1, "halt", n);
      repeat (3) add(1'b1, I_LD, 1'b0, 1'b0, 1'b1, '0, 1'b0, "halted");
      add(1'b0, I_LD, 1'b0, 1'b0, 1'b1, '0, 1'b0, "rst");
      add(1'b1, I_LD, 1'b0, 1'b0, 1'b1, '0, 1'b0, "rst_rel");
      boot_seq();
      instr(I_LDI, 1'b0, -1, 0, -1, "ldi2", n);

      for (int c = 0; c < plan.size(); c++) begin
         @(posedge Clock);
         #2;
         Reset_n = plan[c].rst_n;
         bus.IRregister = plan[c].ir;
         bus.CON = plan[c].con;
         bus.Stop = plan[c].stop;
`ifdef CONTROL_SEQ_MEM_WAIT_EN
         bus.Mem_ready = plan[c].mr;
`endif
         @(negedge Clock);
         chk($sformatf("c%0d_%s_strobes", c, plan[c].tag), 64'(act), 64'(plan[c].exp));
         chk($sformatf("c%0d_%s_run", c, plan[c].tag), 64'(bus.Run), 64'(plan[c].run));
         chk($sformatf("c%0d_bus_src", c), 64'($countones({act.PCout, act.MDRout, act.ZLOout,
             act.ZHIout, act.HIout, act.LOout, act.INPORTout, act.Cout, act.Rout, act.BAout,
             act.Yout}) <= 1), 64'd1);
         chk($sformatf("c%0d_rd_wr", c), 64'(act.Read & act.write), 64'd0);
         case (plan[c].tag)
            "boot":     chk("boot_lit", 64'({act.INPORTout, act.PCin}), 64'h3);
            "ld_T7":    chk("ld_t7_lit", 64'({act.Gra, act.Rin, act.MDRout, act.Read}), 64'he);
            "st_T6":    chk("st_t6_lit", 64'({act.Rout, act.Gra, act.MDRin, act.Read}), 64'he);
            "st_T7":    chk("st_t7_lit", 64'({act.write, 5'($countones(act))}), 64'h21);
            "br0_T6":   chk("br0_t6_lit", 64'({act.ZLOout, act.PCin}), 64'h2);
            "br1_T6":   chk("br1_t6_lit", 64'({act.ZLOout, act.PCin}), 64'h3);
            "midrst":   chk("midrst_lit", 64'({act, bus.Run}), 64'h0);
            "halted":   chk("halt_lit", 64'(bus.Run), 64'h0);
            "ldiw_T1w": chk("mem_wait_lit", 64'(act.Read), 64'h1);
            default: ;
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
